// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, FSM state codes and kernel-slice indexing for conv_sched
package conv_pkg;
  localparam int BIT_LEN = 8;
  localparam int CONV_LPOS = 13;
  localparam int M_LEN = 3;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KER   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  function automatic int kidx(input int r, input int c);
    return (M_LEN * r + c) * BIT_LEN;
  endfunction
endpackage

// File: rtl/conv_sched_vpipe.sv
// conv_sched_vpipe: LAT-deep valid + column-tag delay line with synchronous flush
module conv_sched_vpipe #(
  parameter int LAT = 2,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_v,
  input  logic [W-1:0] in_col,
  output logic         out_v,
  output logic [W-1:0] out_col,
  output logic         busy
);
  localparam int CW = LAT * W;
  logic [LAT-1:0] v_q, v_d;
  logic [CW-1:0] c_q, c_d;
  always_comb begin
    v_d = flush ? '0 : LAT'({v_q, in_v});
    c_d = CW'({c_q, in_col});
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
    end else begin
      v_q <= v_d;
      c_q <= c_d;
    end
  assign out_v = v_q[LAT-1];
  assign out_col = c_q[CW-1 -: W];
  // entries that have not yet reached the output tap
  assign busy = |LAT'({v_q, in_v});
endmodule

// File: rtl/conv_sched.sv
// conv_sched: drives a 3x3 Conv with kernel columns then a strip, tags results by column.
// Optional CONV_SCHED_PERF_EN adds o_perf_cycles / o_perf_stalls counters.
module conv_sched
  import conv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CONV_LAT = 2
) (
  input  logic                 CLK100MHZ,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ADDR_W-1:0]    i_img_w,
  input  logic [9*BIT_LEN-1:0] i_kernel,
  input  logic                 i_out_ready,
  output logic [ADDR_W-1:0]    o_rd_addr,
  output logic                 o_rd_en,
  input  logic [BIT_LEN-1:0]   i_rd_d0,
  input  logic [BIT_LEN-1:0]   i_rd_d1,
  input  logic [BIT_LEN-1:0]   i_rd_d2,
  output logic [BIT_LEN-1:0]   o_dato0,
  output logic [BIT_LEN-1:0]   o_dato1,
  output logic [BIT_LEN-1:0]   o_dato2,
  output logic                 o_selecK_I,
  output logic                 o_conv_valid,
  input  logic [CONV_LPOS-1:0] i_conv_data,
  output logic [CONV_LPOS-1:0] o_res,
  output logic                 o_res_valid,
  output logic [ADDR_W-1:0]    o_res_col,
  output logic                 o_busy,
  output logic                 o_done
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]          o_perf_cycles,
  output logic [15:0]          o_perf_stalls
`endif
);
  logic [2:0] state_q, state_d;
  logic [1:0] kcnt_q, kcnt_d;
  logic [ADDR_W-1:0] w_q, w_d, addr_q, addr_d, col_q, col_d, res_col_q, res_col_d, vp_col;
  logic [9*BIT_LEN-1:0] ker_q, ker_d;
  logic [BIT_LEN-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [CONV_LPOS-1:0] res_q, res_d;
  logic pend_q, pend_d, cv_q, cv_d, sel_q, sel_d, res_v_q, res_v_d;
  logic vp_v, vp_busy, start_acc;

  assign start_acc = state_q == S_IDLE && i_start;
  assign o_rd_en = state_q == S_GAP || (state_q == S_RUN && i_out_ready);
  assign o_rd_addr = addr_q;
  assign o_dato0 = d0_q;
  assign o_dato1 = d1_q;
  assign o_dato2 = d2_q;
  assign o_selecK_I = sel_q;
  assign o_conv_valid = cv_q;
  assign o_res = res_q;
  assign o_res_valid = res_v_q;
  assign o_res_col = res_col_q;
  assign o_busy = state_q != S_IDLE;
  assign o_done = state_q == S_DONE;

  always_comb begin
    state_d = state_q;
    kcnt_d = kcnt_q;
    w_d = w_q;
    ker_d = ker_q;
    addr_d = o_rd_en ? addr_q + ADDR_W'(1) : addr_q;
    pend_d = o_rd_en;
    // a read issued last cycle is presented now; otherwise hold the bus with valid low
    cv_d = pend_q;
    d0_d = pend_q ? i_rd_d0 : d0_q;
    d1_d = pend_q ? i_rd_d1 : d1_q;
    d2_d = pend_q ? i_rd_d2 : d2_q;
    col_d = pend_q ? addr_q - ADDR_W'(1) : col_q;
    sel_d = sel_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_KER;
        kcnt_d = '0;
        ker_d = i_kernel;
        w_d = i_img_w < ADDR_W'(3) ? ADDR_W'(3) : i_img_w;
        addr_d = '0;
        d0_d = i_kernel[kidx(0, 0) +: BIT_LEN];
        d1_d = i_kernel[kidx(0, 1) +: BIT_LEN];
        d2_d = i_kernel[kidx(0, 2) +: BIT_LEN];
        cv_d = 1'b1;
        sel_d = 1'b0;
      end
      S_KER: if (kcnt_q == 2'd2) begin
        state_d = S_GAP;
        sel_d = 1'b1;
      end else begin
        kcnt_d = kcnt_q + 2'd1;
        d0_d = ker_q[kidx(int'(kcnt_d), 0) +: BIT_LEN];
        d1_d = ker_q[kidx(int'(kcnt_d), 1) +: BIT_LEN];
        d2_d = ker_q[kidx(int'(kcnt_d), 2) +: BIT_LEN];
        cv_d = 1'b1;
      end
      S_GAP: state_d = S_RUN;
      S_RUN: if (o_rd_en && addr_q == w_q - ADDR_W'(1)) state_d = S_DRAIN;
      S_DRAIN: if (!pend_q && !cv_q && !vp_busy) begin
        state_d = S_DONE;
        sel_d = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    res_v_d = vp_v;
    res_d = vp_v ? i_conv_data : res_q;
    res_col_d = vp_v ? vp_col : res_col_q;
  end

  always_ff @(posedge CLK100MHZ or posedge i_reset)
    if (i_reset) begin
      state_q <= S_IDLE;
      kcnt_q <= '0;
      w_q <= '0;
      ker_q <= '0;
      addr_q <= '0;
      col_q <= '0;
      pend_q <= 1'b0;
      cv_q <= 1'b0;
      sel_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      res_q <= '0;
      res_v_q <= 1'b0;
      res_col_q <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q <= kcnt_d;
      w_q <= w_d;
      ker_q <= ker_d;
      addr_q <= addr_d;
      col_q <= col_d;
      pend_q <= pend_d;
      cv_q <= cv_d;
      sel_q <= sel_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      res_q <= res_d;
      res_v_q <= res_v_d;
      res_col_q <= res_col_d;
    end

  // columns 0 and 1 only prime the window; result tags start at column 2
  conv_sched_vpipe #(.LAT(CONV_LAT), .W(ADDR_W)) u_vpipe (
    .clk(CLK100MHZ),
    .rst(i_reset),
    .flush(start_acc),
    .in_v(cv_q && sel_q && col_q >= ADDR_W'(2)),
    .in_col(col_q - ADDR_W'(2)),
    .out_v(vp_v),
    .out_col(vp_col),
    .busy(vp_busy)
  );

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] stl_q, stl_d;
  always_comb begin
    cyc_d = start_acc ? '0 : o_busy ? cyc_q + 32'd1 : cyc_q;
    stl_d = start_acc ? '0 : (state_q == S_RUN && !i_out_ready && stl_q != 16'hFFFF) ? stl_q + 16'd1 : stl_q;
  end
  always_ff @(posedge CLK100MHZ or posedge i_reset)
    if (i_reset) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stl_q <= stl_d;
    end
  assign o_perf_cycles = cyc_q;
  assign o_perf_stalls = stl_q;
`endif
endmodule
